// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer:
// op codes, FSM states and the iteration-counter width helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } muldiv_state_e;

    // Bits needed to hold WIDTH-1 in the iteration counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the mul/div datapath.
// Ports: is_div_i selects restoring-divide vs shift-add multiply;
//   mcand_*  multiplicand (shifted left) / divisor (held),
//   mplier_* multiplier (shifted right) / dividend->quotient,
//   acc_*    product accumulator / partial remainder.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [2*WIDTH-1:0]   mcand_o,
    output logic [WIDTH-1:0]     mplier_o,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     diff;
    logic                 q_ok;
    logic [2*WIDTH-1:0]   mul_sum;

    // Partial remainder stays below the divisor, so its low WIDTH
    // bits are enough to form the next shifted remainder.
    assign rem_sh  = {acc_i[WIDTH-1:0], mplier_i[WIDTH-1]};
    assign diff    = {1'b0, rem_sh} - {2'b00, mcand_i[WIDTH-1:0]};
    assign q_ok    = ~diff[WIDTH+1];
    assign mul_sum = acc_i + (mplier_i[0] ? mcand_i : '0);

    always_comb begin
        mcand_o  = mcand_i;
        mplier_o = mplier_i;
        acc_o    = acc_i;
        if (is_div_i) begin
            mplier_o = {mplier_i[WIDTH-2:0], q_ok};
            acc_o    = {{(WIDTH-1){1'b0}}, (q_ok ? diff[WIDTH:0] : rem_sh)};
        end else begin
            mcand_o  = mcand_i << 1;
            mplier_o = mplier_i >> 1;
            acc_o    = mul_sum;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall.
// Ports: clk, reset (async, active-high); start/op/op_a/op_b issue an op;
//   mf_req, mt_hi, mt_lo HI/LO access; flush aborts; busy, stall, done,
//   hi, lo outputs. Define MULDIV_EARLY_EXIT_EN for multiply early exit.
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);
    localparam int W2 = 2 * WIDTH;

    muldiv_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sa_q, sa_d;
    logic             neg_q, neg_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    muldiv_op_e       op_e;
    logic             in_div, in_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    logic [W2-1:0]    step_mcand, step_acc;
    logic [WIDTH-1:0] step_mplier;
    logic             early_exit;

    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_e      = muldiv_op_e'(op);
    assign in_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign in_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign a_neg     = in_signed & op_a[WIDTH-1];
    assign b_neg     = in_signed & op_b[WIDTH-1];
    assign abs_a     = a_neg ? -op_a : op_a;
    assign abs_b     = b_neg ? -op_b : op_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (div_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_i    (acc_q),
        .mcand_o  (step_mcand),
        .mplier_o (step_mplier),
        .acc_o    (step_acc)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    // Product is final once no multiplier bits remain to be consumed.
    assign early_exit = ~div_q & ~|step_mplier;
`else
    assign early_exit = 1'b0;
`endif

    // Divide by zero: the restoring loop leaves |a| as remainder, so the
    // sign fixup of the remainder already reproduces op_a in HI.
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = dz_q ? '1 : (neg_q ? -mplier_q : mplier_q);
    assign rem_fix  = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | mf_req | mt_hi | mt_lo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sa_d     = sa_q;
        neg_d    = neg_q;
        div_d    = div_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mt_hi) hi_d = op_a;
                if (mt_lo) lo_d = op_a;
                if (start && !flush) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(WIDTH - 1);
                    mcand_d  = {{WIDTH{1'b0}}, (in_div ? abs_b : abs_a)};
                    mplier_d = in_div ? abs_a : abs_b;
                    acc_d    = '0;
                    sa_d     = a_neg;
                    neg_d    = a_neg ^ b_neg;
                    div_d    = in_div;
                    dz_d     = in_div & (op_b == '0);
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                    acc_d    = step_acc;
                    if (cnt_q == '0 || early_exit) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sa_q     <= 1'b0;
            neg_q    <= 1'b0;
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sa_q     <= sa_d;
            neg_q    <= neg_d;
            div_q    <= div_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Randomized and directed bench for ex_muldiv_ctrl against a
// plain-arithmetic reference model of HI/LO results and latency.
module tb_ex_muldiv_ctrl;

    localparam int W = 32;
`ifdef MULDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         mf_req;
    logic         mt_hi;
    logic         mt_lo;
    logic         flush;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    ex_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .mf_req (mf_req),
        .mt_hi  (mt_hi),
        .mt_lo  (mt_lo),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset)
            assert (!(start && (mt_hi || mt_lo)))
            else $error("start issued together with mt_hi/mt_lo");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results straight from 64-bit integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        longint x, y;
        longint unsigned ux;
        case (o)
            2'b00: begin
                x = longint'($signed(a)) * longint'($signed(b));
                {eh, el} = x;
            end
            2'b01: begin
                ux = 64'(a) * 64'(b);
                {eh, el} = ux;
            end
            default: begin
                if (b == '0) begin
                    el = '1;
                    eh = a;
                end else if (o == 2'b10) begin
                    x  = longint'($signed(a));
                    y  = longint'($signed(b));
                    el = 32'(x / y);
                    eh = 32'(x % y);
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
        logic [W-1:0] m;
        int k;
        if (!EARLY || o[1]) return W + 1;
        m = (o == 2'b00 && b[W-1]) ? -b : b;
        k = 0;
        for (int i = 0; i < W; i++)
            if (m[i]) k = i;
        return k + 2;
    endfunction

    // Called right after the accepting edge; follows the op to done.
    task automatic wait_result(input string tag, input int lat,
                               input logic [W-1:0] eh, input logic [W-1:0] el);
        int cyc, bcnt;
        bit got;
        bcnt = busy ? 1 : 0;
        cyc  = 0;
        got  = 0;
        while (!got && cyc < 200) begin
            tick();
            cyc++;
            if (done) got = 1;
            else if (busy) bcnt++;
        end
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_busy"}, bcnt, lat);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        tick();
        check({tag, "_pulse"}, done, 0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        model(o, a, b, eh, el);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        tick();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        wait_result(tag, exp_lat(o, b), eh, el);
    endtask

    initial begin : main
        logic [W-1:0] eh, el, eh2, el2, oh, ol, a, b;
        logic [1:0]   o;
        int scnt, dn, lat;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        op_a   = '0;
        op_b   = '0;
        mf_req = 1'b0;
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
        flush  = 1'b0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;

        op_a  = 32'h1234_5678;
        mt_lo = 1'b1;
        check("mt_idle_stall", stall, 0);
        tick();
        mt_lo = 1'b0;
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi", hi, 0);
        op_a  = 32'hCAFE_BABE;
        mt_hi = 1'b1;
        tick();
        mt_hi = 1'b0;
        check("mthi_hi", hi, 32'hCAFE_BABE);
        mf_req = 1'b1;
        #1;
        check("mf_idle_stall", stall, 0);
        mf_req = 1'b0;

        run_op("mult_neg3x7", 2'b00, -32'sd3, 32'd7);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m7_2", 2'b10, -32'sd7, 32'd2);
        run_op("div_by0", 2'b10, 32'd5, 32'd0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("multu_b1", 2'b01, 32'hDEAD_BEEF, 32'd1);

        // MFHI right behind MULTU: stalled until the result lands.
        a = 32'hFFFF_0001;
        b = 32'h8765_4321;
        model(2'b01, a, b, eh, el);
        lat   = exp_lat(2'b01, b);
        start = 1'b1;
        op    = 2'b01;
        op_a  = a;
        op_b  = b;
        tick();
        start  = 1'b0;
        mf_req = 1'b1;
        scnt = 0;
        dn   = 0;
        while (busy && dn < 200) begin
            if (stall) scnt++;
            tick();
            dn++;
        end
        check("mf_stall_cnt", scnt, lat);
        check("mf_stall_rel", stall, 0);
        check("mf_done", done, 1);
        check("mf_hi", hi, eh);
        mf_req = 1'b0;
        tick();

        // Second mul/div held by the pipeline while the first runs.
        model(2'b11, 32'd1000, 32'd33, eh, el);
        model(2'b00, -32'sd12345, 32'd678, eh2, el2);
        lat   = exp_lat(2'b11, 32'd33);
        start = 1'b1;
        op    = 2'b11;
        op_a  = 32'd1000;
        op_b  = 32'd33;
        tick();
        op   = 2'b00;
        op_a = -32'sd12345;
        op_b = 32'd678;
        scnt = 0;
        dn   = 0;
        while (busy && dn < 200) begin
            if (stall) scnt++;
            tick();
            dn++;
        end
        check("b2b_stall_cnt", scnt, lat);
        check("b2b_stall_rel", stall, 0);
        check("b2b_done1", done, 1);
        check("b2b_hi1", hi, eh);
        check("b2b_lo1", lo, el);
        tick();
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        wait_result("b2b_op2", exp_lat(2'b00, -32'sd12345), eh2, el2);

        // Flush at RUN cycle 10.
        oh    = hi;
        ol    = lo;
        start = 1'b1;
        op    = 2'b11;
        op_a  = 32'hFFFF_FFF0;
        op_b  = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("fl_running", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_idle", busy, 0);
        dn = 0;
        repeat (40) begin
            tick();
            if (done) dn++;
        end
        check("fl_nodone", dn, 0);
        check("fl_hi", hi, oh);
        check("fl_lo", lo, ol);

        flush = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("fl_start_ign", busy, 0);

        for (int n = 0; n < 24; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 15));
                2: b = '0;
                default: b = -32'($urandom_range(1, 9));
            endcase
            run_op($sformatf("rnd%0d_op%0d", n, o), o, a, b);
        end

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        op    = 2'b11;
        op_a  = 32'h7777_7777;
        op_b  = 32'd5;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("ar_prebusy", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_stall", stall, 0);
        check("ar_done", done, 0);
        check("ar_hi", hi, 0);
        check("ar_lo", lo, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
